// File: rtl/caliptra_axil_reg_bank.sv
// caliptra_axil_reg_bank
//   AXI4-Lite slave register bank. It holds NUM_CTRL read/write control
//   words, NUM_STAT read-only status words, a sticky EVENT register and an
//   EVENT_EN mask. An interrupt is raised when any enabled event is pending.
// Ports
//   core_clk, S_AXI_ARESETN : clock and synchronous active-low reset
//   S_AXI_AW*/W*/B*         : AXI4-Lite write address / data / response
//   S_AXI_AR*/R*            : AXI4-Lite read address / data
//   ctrl_out                : control words, word i at [32i+31:32i]
//   stat_in                 : status words, same packing
//   event_in                : event sources; a rising edge sets EVENT
//   irq                     : registered OR of (EVENT & EVENT_EN)
module caliptra_axil_reg_bank #(
  parameter int          NUM_CTRL = 4,
  parameter int          NUM_STAT = 4,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic                     core_clk,
  input  logic                     S_AXI_ARESETN,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  output logic [1:0]               S_AXI_BRESP,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic [NUM_CTRL*32-1:0]   ctrl_out,
  input  logic [NUM_STAT*32-1:0]   stat_in,
  input  logic [31:0]              event_in,
  output logic                     irq
);

  localparam logic [31:0] IDX_STAT = 32'(NUM_CTRL);
  localparam logic [31:0] IDX_EVT  = 32'(NUM_CTRL + NUM_STAT);
  localparam logic [31:0] IDX_EN   = 32'(NUM_CTRL + NUM_STAT + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Byte-strobe merge: strobed bytes take the new data, others keep old.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  logic                   rst_done_q, rst_done_d;
  logic                   aw_full_q, aw_full_d;
  logic [ADDR_W-1:0]      aw_addr_q, aw_addr_d;
  logic                   w_full_q, w_full_d;
  logic [31:0]            w_data_q, w_data_d;
  logic [3:0]             w_strb_q, w_strb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
  logic [31:0]            event_q, event_d;
  logic [31:0]            event_en_q, event_en_d;
  logic [31:0]            evt_dly_q, evt_dly_d;
  logic                   irq_q, irq_d;

  logic        aw_hs_s, w_hs_s, ar_hs_s, wr_go_s;
  logic [31:0] aw_idx_s, ar_idx_s;
  logic [31:0] w1c_s;
  logic [1:0]  wr_resp_s;
  logic [31:0] rd_ctrl_s, rd_stat_s, rd_data_s;
  logic [1:0]  rd_resp_s;

  // Ready signals stay low until the first edge after reset release.
  assign S_AXI_AWREADY = rst_done_q && !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = rst_done_q && !w_full_q && !bvalid_q;
  assign S_AXI_ARREADY = rst_done_q && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign irq           = irq_q;

  // Handshakes, holding registers and response-channel next state.
  always_comb begin
    aw_hs_s    = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs_s     = S_AXI_WVALID && S_AXI_WREADY;
    ar_hs_s    = S_AXI_ARVALID && S_AXI_ARREADY;
    wr_go_s    = aw_full_q && w_full_q;
    rst_done_d = 1'b1;

    if (wr_go_s)      aw_full_d = 1'b0;
    else if (aw_hs_s) aw_full_d = 1'b1;
    else              aw_full_d = aw_full_q;
    if (aw_hs_s) aw_addr_d = S_AXI_AWADDR;
    else         aw_addr_d = aw_addr_q;

    if (wr_go_s)     w_full_d = 1'b0;
    else if (w_hs_s) w_full_d = 1'b1;
    else             w_full_d = w_full_q;
    if (w_hs_s) begin
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end else begin
      w_data_d = w_data_q;
      w_strb_d = w_strb_q;
    end

    if (wr_go_s)                        bvalid_d = 1'b1;
    else if (bvalid_q && S_AXI_BREADY)  bvalid_d = 1'b0;
    else                                bvalid_d = bvalid_q;
    if (wr_go_s) bresp_d = wr_resp_s;
    else         bresp_d = bresp_q;

    if (ar_hs_s)                        rvalid_d = 1'b1;
    else if (rvalid_q && S_AXI_RREADY)  rvalid_d = 1'b0;
    else                                rvalid_d = rvalid_q;
    if (ar_hs_s) begin
      rdata_d = rd_data_s;
      rresp_d = rd_resp_s;
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
  end

  // Write decode: applies the held AW/W pair to the register file.
  always_comb begin
    aw_idx_s = 32'(aw_addr_q[ADDR_W-1:2]);
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_d[32*i +: 32] = (wr_go_s && (aw_idx_s == 32'(i)))
                           ? strb_merge(ctrl_q[32*i +: 32], w_data_q, w_strb_q)
                           : ctrl_q[32*i +: 32];
    end
    if (wr_go_s && (aw_idx_s == IDX_EN)) event_en_d = strb_merge(event_en_q, w_data_q, w_strb_q);
    else                                 event_en_d = event_en_q;
    // W1C mask: only strobed bytes of the written data clear bits.
    if (wr_go_s && (aw_idx_s == IDX_EVT)) w1c_s = strb_merge(32'h0, w_data_q, w_strb_q);
    else                                  w1c_s = 32'h0;
    if ((aw_idx_s < IDX_STAT) || (aw_idx_s == IDX_EVT) || (aw_idx_s == IDX_EN))
      wr_resp_s = RESP_OKAY;
    else
      wr_resp_s = RESP_SLVERR;
  end

  // Event capture: rising edges set, W1C clears, set wins on collision.
  always_comb begin
    evt_dly_d = event_in;
    event_d   = (event_q & ~w1c_s) | (event_in & ~evt_dly_q);
    irq_d     = |(event_q & event_en_q);
  end

  // Read decode as AND-OR muxes over the word index.
  always_comb begin
    ar_idx_s  = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
    rd_ctrl_s = 32'h0;
    rd_stat_s = 32'h0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      rd_ctrl_s = rd_ctrl_s | (ctrl_q[32*i +: 32] & {32{ar_idx_s == 32'(i)}});
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      rd_stat_s = rd_stat_s | (stat_in[32*j +: 32] & {32{ar_idx_s == 32'(NUM_CTRL + j)}});
    end
    if (ar_idx_s < IDX_STAT) begin
      rd_data_s = rd_ctrl_s;
      rd_resp_s = RESP_OKAY;
    end else if (ar_idx_s < IDX_EVT) begin
      rd_data_s = rd_stat_s;
      rd_resp_s = RESP_OKAY;
    end else if (ar_idx_s == IDX_EVT) begin
      rd_data_s = event_q;
      rd_resp_s = RESP_OKAY;
    end else if (ar_idx_s == IDX_EN) begin
      rd_data_s = event_en_q;
      rd_resp_s = RESP_OKAY;
    end else begin
      rd_data_s = 32'h0;
      rd_resp_s = RESP_SLVERR;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge core_clk) begin
    if (!S_AXI_ARESETN) begin
      rst_done_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= {ADDR_W{1'b0}};
      w_full_q   <= 1'b0;
      w_data_q   <= 32'h0;
      w_strb_q   <= 4'h0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      ctrl_q     <= {NUM_CTRL{CTRL_RST}};
      event_q    <= 32'h0;
      event_en_q <= 32'h0;
      evt_dly_q  <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      rst_done_q <= rst_done_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      ctrl_q     <= ctrl_d;
      event_q    <= event_d;
      event_en_q <= event_en_d;
      evt_dly_q  <= evt_dly_d;
      irq_q      <= irq_d;
    end
  end

endmodule
